nabp_filter_mapper: RTL
=======================

# nabp_filter_mapper

Buffers filtered projection samples from the upstream filter stream and maps them onto a shift line whose taps feed the processing-element partitions. It sits directly downstream of the shifter. Each cycle the shifter asserts `fm_shift_enable`, the line advances by one sample. A small input FIFO decouples the bursty filter stream from the shifter's irregular shift cadence.

## Interface
- `DATA_WIDTH`, 16: filtered sample width (signed, two's complement).
- `LINE_LEN`, 32: shift line length in samples.
- `NUM_TAPS`, 4: number of partition taps.
- `TAP_STRIDE`, 8: tap i reads line position i*TAP_STRIDE. Requires (NUM_TAPS-1)*TAP_STRIDE < LINE_LEN.
- `FIFO_DEPTH`, 8: input FIFO depth; power of two, ≥ 2.
- `clk` in 1: clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `sc_clear` in 1: single-cycle pulse from state control; flushes the FIFO and the line.
- `hf_data` in DATA_WIDTH: filtered sample from the filter.
- `hf_valid` in 1: `hf_data` is valid.
- `hf_ready` out 1: FIFO accepts a sample this cycle.
- `fm_shift_enable` in 1: advance line by one (from shifter).
- `pe_taps` out NUM_TAPS*DATA_WIDTH: tap i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `pe_valid` out 1: line fully populated since the last clear.
- `fifo_level` out clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `underflow` out 1: sticky; a shift occurred with the FIFO empty.

## Operation
- FIFO
  - Circular buffer with read/write pointers and an occupancy count.
  - `hf_ready` = reset_n && (count < FIFO_DEPTH), derived from registered count only. It does not depend on a same-cycle pop.
  - Push when `hf_valid && hf_ready`.
  - Pop when `fm_shift_enable` and count > 0.
  - Push and pop in the same cycle leave count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Shift line: LINE_LEN registers, line[0] is the entry point. On `fm_shift_enable`:
  - line[k] <= line[k-1] for k ≥ 1.
  - line[0] <= FIFO head if count > 0. Otherwise line[0] <= 0 and `underflow` <= 1.
  - A sample pushed into an empty FIFO in the same cycle is not bypassed. It is stored and consumed on a later shift.
- Fill FSM
  - States:
    - `empty_s`: after reset or clear.
    - `fill_s`: filling the line.
    - `full_s`: line fully populated.
  - A counter `fill_cnt` (width clog2(LINE_LEN+1)) counts shifts since the clear.
  - Transitions:
    - `empty_s` -> `fill_s` on the first shift; `fill_cnt` <= 1.
    - `fill_s` increments `fill_cnt` on each shift and moves to `full_s` when it reaches LINE_LEN.
    - `full_s` holds until clear or reset.
  - Underflow shifts still count toward the fill.
- `pe_valid` = (state == `full_s`).
- Taps: `pe_taps` are driven straight from line registers (no extra pipeline stage).
- `sc_clear`
  - Next cycle: count, pointers, all line registers, `fill_cnt` and `underflow` are 0, and state is `empty_s`.
  - Clear takes priority over a same-cycle push or shift; that push and shift are discarded.
- Reset (`reset_n` low at a clock edge) has the same effect as clear, at any point mid-operation. `hf_ready` is 0 while `reset_n` is low.

## Timing
- Reset values:
  - `hf_ready` = 1 after the first edge with `reset_n` high; 0 while `reset_n` is low.
  - `pe_taps` = 0, `pe_valid` = 0, `fifo_level` = 0, `underflow` = 0.
- Push latency: a sample accepted at edge n is visible in `fifo_level` after edge n. It is poppable by a shift at edge n+1 or later.
- Shift latency: a shift at edge n updates `pe_taps` after edge n, i.e. visible in cycle n+1.
- A sample popped at edge n appears on tap i after edge n + i*TAP_STRIDE, given consecutive shifts.
- `pe_valid` rises in the cycle after the LINE_LEN-th shift since clear.
- Full FIFO: `hf_ready` = 0 even if a pop occurs in the same cycle. It rises the cycle after the pop.
- Back-to-back shifts every cycle are sustained. The FIFO drains at one sample per cycle.
- `fifo_level` never exceeds FIFO_DEPTH and never wraps below 0.

## Test plan
- Reset, then push 0x0001..0x0008 with no shifts.
  - `fifo_level` = 8 and `hf_ready` = 0 after the 8th push.
  - A 9th `hf_valid` is not accepted.
- Prefill with the ramp 1..40 and shift every cycle for 32 cycles.
  - After shift k, line[0] = k.
  - `pe_valid` rises after shift 32.
  - At that point `pe_taps` = {tap3=8, tap2=16, tap1=24, tap0=32}.
- Shift with the FIFO empty.
  - `underflow` = 1 and stays high.
  - line[0] = 0.
  - Fill still counts: 32 shifts with no data give `pe_valid` = 1 and all taps 0.
- Simultaneous push and shift on an empty FIFO.
  - Underflow sets, `fifo_level` = 1, line[0] = 0.
  - The next shift loads the pushed value.
- Mid-fill (`fill_cnt` = 10, `fifo_level` = 5), pulse `sc_clear` together with `fm_shift_enable` and `hf_valid`.
  - Next cycle: all outputs are 0, `hf_ready` = 1, and `pe_valid` does not rise until 32 more shifts.
  - Repeat the same check with `reset_n` low instead of `sc_clear`.
- Random `hf_valid` and `fm_shift_enable` (~50% each) for 2000 cycles against a scoreboard.
  - Tap sequences match the pushed order, with zeros exactly at underflow shifts.
  - `fifo_level` is never greater than 8.

Source files
------------

// File: rtl/nabp_filter_mapper.sv
// nabp_filter_mapper: input FIFO feeding a shift line whose taps drive the
// processing-element partitions. The shifter's enable advances the line by one
// sample per cycle; a fill FSM reports when the line is fully populated.
module nabp_filter_mapper #(
  parameter int DATA_WIDTH = 16,
  parameter int LINE_LEN   = 32,
  parameter int NUM_TAPS   = 4,
  parameter int TAP_STRIDE = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           sc_clear,
  input  logic [DATA_WIDTH-1:0]          hf_data,
  input  logic                           hf_valid,
  output logic                           hf_ready,
  input  logic                           fm_shift_enable,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] pe_taps,
  output logic                           pe_valid,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic                           underflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = $clog2(LINE_LEN + 1);

  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(FIFO_DEPTH);
  localparam logic [FW-1:0] FILL_ONE  = FW'(1);
  localparam logic [FW-1:0] FILL_LEN  = FW'(LINE_LEN);

  typedef enum logic [1:0] {
    empty_s = 2'd0,
    fill_s  = 2'd1,
    full_s  = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic [DATA_WIDTH-1:0] line_r [LINE_LEN];
  logic [FW-1:0]         fill_cnt_r;
  state_t                state_r;
  logic                  underflow_r;

  logic                  ready_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  flush_s;
  logic [FW-1:0]         fill_next_s;

  // Handshake and flush decode; ready looks only at the registered count.
  always_comb begin
    ready_s     = reset_n && (count_r < CNT_DEPTH);
    push_s      = hf_valid && ready_s;
    pop_s       = fm_shift_enable && (count_r != CNT_ZERO);
    flush_s     = !reset_n || sc_clear;
    fill_next_s = fill_cnt_r + FILL_ONE;
  end

  // FIFO pointers, occupancy and storage; a flush drops any same-cycle push/pop.
  always_ff @(posedge clk) begin
    if (flush_s) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= hf_data;
        wr_ptr_r             <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Shift line; an empty FIFO on a shift injects a zero sample.
  always_ff @(posedge clk) begin
    if (flush_s) begin
      for (int k = 0; k < LINE_LEN; k++) line_r[k] <= '0;
    end else if (fm_shift_enable) begin
      for (int k = 1; k < LINE_LEN; k++) line_r[k] <= line_r[k-1];
      line_r[0] <= pop_s ? fifo_mem_r[rd_ptr_r] : '0;
    end
  end

  // Sticky underflow flag, set by any shift that finds the FIFO empty.
  always_ff @(posedge clk) begin
    if (flush_s) begin
      underflow_r <= 1'b0;
    end else if (fm_shift_enable && !pop_s) begin
      underflow_r <= 1'b1;
    end
  end

  // Fill FSM: counts shifts since the last clear, underflow shifts included.
  always_ff @(posedge clk) begin
    if (flush_s) begin
      state_r    <= empty_s;
      fill_cnt_r <= '0;
    end else if (fm_shift_enable) begin
      case (state_r)
        empty_s: begin
          fill_cnt_r <= FILL_ONE;
          state_r    <= (FILL_ONE == FILL_LEN) ? full_s : fill_s;
        end
        fill_s: begin
          fill_cnt_r <= fill_next_s;
          if (fill_next_s == FILL_LEN) state_r <= full_s;
        end
        full_s:  state_r <= full_s;
        default: state_r <= empty_s;
      endcase
    end
  end

  // Taps come straight from line registers.
  for (genvar i = 0; i < NUM_TAPS; i++) begin : g_tap
    assign pe_taps[i*DATA_WIDTH +: DATA_WIDTH] = line_r[i*TAP_STRIDE];
  end

  assign hf_ready   = ready_s;
  assign pe_valid   = (state_r == full_s);
  assign fifo_level = count_r;
  assign underflow  = underflow_r;

endmodule
